// File: rtl/banco_registradores_parametrizado_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_componentes_cpu
// Purpose  : Shared definitions for the CPU register-file components:
//            default data width and register count, the clear-FSM state
//            encoding and an address range helper.
// Ports    : (package - no ports)
// Revision : 1.0 - initial release
// ============================================================================
package pkg_componentes_cpu;

  localparam int C_LARGURA_PADRAO  = 32;
  localparam int C_NUM_REGS_PADRAO = 32;

  // Clear sequencer states: idle, or sweeping zeros through the bank.
  typedef enum logic [0:0] {
    OCIOSO   = 1'b0,
    LIMPANDO = 1'b1
  } estado_limpeza_t;

  // True when an address selects a physically present register. The
  // address bus is $clog2(NUM_REGS) wide, so for non power-of-two banks
  // it can encode indices past the last register.
  function automatic logic endereco_valido(input int unsigned endereco,
                                           input int unsigned num_regs);
    return (endereco < num_regs);
  endfunction

endpackage : pkg_componentes_cpu
`default_nettype wire

// File: rtl/banco_registradores_parametrizado_contador_limpeza.sv
`default_nettype none
// ============================================================================
// Module   : contador_limpeza
// Purpose  : Clear-sequence index counter. Loaded to zero when a clear is
//            requested, then stepped once per cycle while enabled. Flags the
//            last register so the sequencer can finish; wraps back to zero
//            there so it never points past NUM_REGS-1.
// Ports    : clk         - clock, rising edge
//            rst_n       - asynchronous active-low reset
//            i_carregar  - load zero (start of a clear)
//            i_habilitar - advance one register
//            cnt         - current register index being cleared
//            fim         - cnt is the last register (NUM_REGS-1)
// Revision : 1.0 - initial release
// ============================================================================
module contador_limpeza
  import pkg_componentes_cpu::*;
#(
  parameter int NUM_REGS = C_NUM_REGS_PADRAO,
  localparam int END     = $clog2(NUM_REGS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_carregar,
  input  logic           i_habilitar,
  output logic [END-1:0] cnt,
  output logic           fim
);

  localparam logic [END-1:0] C_ULTIMO = END'(NUM_REGS - 1);

  logic [END-1:0] r_cnt;
  logic           w_fim;

  // Terminal count compares against NUM_REGS-1 rather than relying on the
  // natural binary rollover, which only matches power-of-two banks.
  assign w_fim = (r_cnt == C_ULTIMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_carregar) begin
      r_cnt <= '0;
    end else if (i_habilitar) begin
      r_cnt <= w_fim ? '0 : (r_cnt + 1'b1);
    end
  end

  assign cnt = r_cnt;
  assign fim = w_fim;

endmodule : contador_limpeza
`default_nettype wire

// File: rtl/banco_registradores_parametrizado.sv
`default_nettype none
// ============================================================================
// Module   : banco_registradores_parametrizado
// Purpose  : Parameterised register file with two combinational read ports,
//            one write port, optional hard-wired zero register, optional
//            write-to-read bypass and a multi-cycle clear-all sequence.
// Ports    : clock        - clock, all state updates on rising edge
//            reset        - asynchronous active-low reset
//            regWrite     - write enable
//            RS, RT       - read addresses
//            RD           - write address
//            dadosEscrita - write data
//            limpar       - one-cycle clear-all request
//            leituraRS    - data at RS
//            leituraRT    - data at RT
//            ocupado      - clear sequence in progress
// Revision : 1.0 - initial release
// ============================================================================
module banco_registradores_parametrizado
  import pkg_componentes_cpu::*;
#(
  parameter int LARGURA   = C_LARGURA_PADRAO,
  parameter int NUM_REGS  = C_NUM_REGS_PADRAO,
  parameter bit ZERO_FIXO = 1'b1,
  parameter bit BYPASS    = 1'b1,
  localparam int END      = $clog2(NUM_REGS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               regWrite,
  input  logic [END-1:0]     RS,
  input  logic [END-1:0]     RT,
  input  logic [END-1:0]     RD,
  input  logic [LARGURA-1:0] dadosEscrita,
  input  logic               limpar,
  output logic [LARGURA-1:0] leituraRS,
  output logic [LARGURA-1:0] leituraRT,
  output logic               ocupado
);

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  estado_limpeza_t r_estado;
  estado_limpeza_t w_prox_estado;
  logic            w_carregar;
  logic            w_ocioso;
  logic            w_limpando;
  logic [END-1:0]  w_cnt;
  logic            w_fim;

  assign w_ocioso   = (r_estado == OCIOSO);
  assign w_limpando = (r_estado == LIMPANDO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // limpar is only honoured while idle; a request arriving mid-clear is
  // dropped so the sweep length stays exactly NUM_REGS cycles.
  always_comb begin
    w_prox_estado = r_estado;
    w_carregar    = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (limpar) begin
          w_prox_estado = LIMPANDO;
          w_carregar    = 1'b1;
        end
      end
      LIMPANDO: begin
        if (w_fim) begin
          w_prox_estado = OCIOSO;
        end
      end
      default: begin
        w_prox_estado = OCIOSO;
      end
    endcase
  end

  contador_limpeza #(
    .NUM_REGS (NUM_REGS)
  ) u_contador_limpeza (
    .clk         (clock),
    .rst_n       (reset),
    .i_carregar  (w_carregar),
    .i_habilitar (w_limpando),
    .cnt         (w_cnt),
    .fim         (w_fim)
  );

  assign ocupado = w_limpando;

  // --------------------------------------------------------------------------
  // Write qualification
  // --------------------------------------------------------------------------
  // A write lands only while idle, to a present register, and never to
  // register 0 when it is hard-wired. A write issued together with limpar
  // still lands; the sweep that follows wipes it.
  logic w_rd_valido;
  logic w_escrita_ok;

  assign w_rd_valido  = endereco_valido(32'(RD), NUM_REGS) &&
                        !(ZERO_FIXO && (RD == '0));
  assign w_escrita_ok = regWrite && w_ocioso && w_rd_valido;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [LARGURA-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_limpando) begin
      r_regs[w_cnt] <= '0;
    end else if (w_escrita_ok) begin
      r_regs[RD] <= dadosEscrita;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  // Both ports share the same rules: zero while clearing, zero for absent
  // registers and for a hard-wired register 0, otherwise stored data or, with
  // bypass on, the data of a qualified same-cycle write to that address.
  for (genvar p = 0; p < 2; p++) begin : g_porta_leitura
    logic [END-1:0]     w_end;
    logic               w_end_valido;
    logic [LARGURA-1:0] w_dado;

    assign w_end        = (p == 0) ? RS : RT;
    assign w_end_valido = endereco_valido(32'(w_end), NUM_REGS) &&
                          !(ZERO_FIXO && (w_end == '0));

    always_comb begin
      w_dado = '0;
      if (w_ocioso && w_end_valido) begin
        if (BYPASS && w_escrita_ok && (RD == w_end)) begin
          w_dado = dadosEscrita;
        end else begin
          w_dado = r_regs[w_end];
        end
      end
    end
  end

  assign leituraRS = g_porta_leitura[0].w_dado;
  assign leituraRT = g_porta_leitura[1].w_dado;

endmodule : banco_registradores_parametrizado
`default_nettype wire

// File: tb/tb_banco_registradores_parametrizado.sv
`default_nettype none
// ============================================================================
// Module   : tb_banco_registradores_parametrizado
// Purpose  : Directed self-checking bench. Three instances: default
//            configuration (A), bypass disabled (B, same stimulus as A) and a
//            20 x 16-bit bank (C).
// Revision : 1.0 - initial release
// ============================================================================
module tb_banco_registradores_parametrizado;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Shared stimulus for A and B
  logic        s_we, s_limpar;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [31:0] s_dados;
  logic [31:0] a_rs, a_rt, b_rs, b_rt;
  logic        a_oc, b_oc;

  // Stimulus for C
  logic        c_we, c_limpar;
  logic [4:0]  c_rs, c_rt, c_rd;
  logic [15:0] c_dados, c_lrs, c_lrt;
  logic        c_oc;

  int n_tests = 0;
  int n_fail  = 0;
  int k;

  banco_registradores_parametrizado #(
    .LARGURA(32), .NUM_REGS(32), .ZERO_FIXO(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clock(clk), .reset(rst_n), .regWrite(s_we), .RS(s_rs), .RT(s_rt),
    .RD(s_rd), .dadosEscrita(s_dados), .limpar(s_limpar),
    .leituraRS(a_rs), .leituraRT(a_rt), .ocupado(a_oc)
  );

  banco_registradores_parametrizado #(
    .LARGURA(32), .NUM_REGS(32), .ZERO_FIXO(1'b1), .BYPASS(1'b0)
  ) dut_b (
    .clock(clk), .reset(rst_n), .regWrite(s_we), .RS(s_rs), .RT(s_rt),
    .RD(s_rd), .dadosEscrita(s_dados), .limpar(s_limpar),
    .leituraRS(b_rs), .leituraRT(b_rt), .ocupado(b_oc)
  );

  banco_registradores_parametrizado #(
    .LARGURA(16), .NUM_REGS(20), .ZERO_FIXO(1'b1), .BYPASS(1'b1)
  ) dut_c (
    .clock(clk), .reset(rst_n), .regWrite(c_we), .RS(c_rs), .RT(c_rt),
    .RD(c_rd), .dadosEscrita(c_dados), .limpar(c_limpar),
    .leituraRS(c_lrs), .leituraRT(c_lrt), .ocupado(c_oc)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    return (i == 0) ? 32'h0 : (32'hA5A5_0000 + 32'(i));
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    s_we = 1'b0; s_limpar = 1'b0; s_rs = '0; s_rt = '0; s_rd = '0; s_dados = '0;
    c_we = 1'b0; c_limpar = 1'b0; c_rs = '0; c_rt = '0; c_rd = '0; c_dados = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    s_rs = 5'd3;
    #1;
    check("rst_ocupado_a", 32'(a_oc), 32'd0);
    check("rst_ocupado_b", 32'(b_oc), 32'd0);
    check("rst_ocupado_c", 32'(c_oc), 32'd0);
    check("rst_read_a",    a_rs,      32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      s_rs = 5'(i); s_rt = 5'(i);
      #1;
      check("post_rst_rs", a_rs, 32'd0);
      check("post_rst_rt", a_rt, 32'd0);
    end

    // ---------------- write sweep ----------------
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      s_we = 1'b1; s_rd = 5'(i); s_dados = 32'hA5A5_0000 + 32'(i);
    end
    @(negedge clk);
    s_we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      s_rs = 5'(i); s_rt = 5'(31 - i);
      #1;
      check("sweep_rs_a", a_rs, sweep_val(i));
      check("sweep_rt_a", a_rt, sweep_val(31 - i));
      check("sweep_rs_b", b_rs, sweep_val(i));
    end

    // ---------------- bypass ----------------
    @(negedge clk);
    s_we = 1'b1; s_rd = 5'd5; s_rs = 5'd5; s_rt = 5'd6; s_dados = 32'h0000_1234;
    #1;
    check("bypass_rs_a",    a_rs, 32'h0000_1234);
    check("nobypass_rs_b",  b_rs, 32'hA5A5_0005);
    check("bypass_rt_a",    a_rt, 32'hA5A5_0006);
    @(posedge clk); #1;
    check("nobypass_post_b", b_rs, 32'h0000_1234);
    @(negedge clk);
    s_we = 1'b0;
    #1;
    check("stored_rs_a", a_rs, 32'h0000_1234);
    check("stored_rs_b", b_rs, 32'h0000_1234);

    // write to register 0 is ignored, bypass included
    @(negedge clk);
    s_we = 1'b1; s_rd = 5'd0; s_rs = 5'd0; s_dados = 32'h0000_DEAD;
    #1;
    check("zero_bypass_a", a_rs, 32'd0);
    check("zero_bypass_b", b_rs, 32'd0);
    @(negedge clk);
    s_we = 1'b0;
    #1;
    check("zero_stored_a", a_rs, 32'd0);

    // ---------------- clear with simultaneous write ----------------
    @(negedge clk);
    s_limpar = 1'b1; s_we = 1'b1; s_rd = 5'd7; s_rs = 5'd7; s_dados = 32'h0000_00FF;
    #1;
    check("clr_wr_bypass_a", a_rs, 32'h0000_00FF);
    check("clr_wr_old_b",    b_rs, 32'hA5A5_0007);
    @(posedge clk); #1;
    s_limpar = 1'b0; s_rd = 5'd9; s_rs = 5'd9; s_dados = 32'h0000_5555;
    #1;
    check("clr_ocupado_a", 32'(a_oc), 32'd1);
    check("clr_busy_rs_a", a_rs, 32'd0);
    k = 0;
    while (a_oc && k < 100) begin
      s_limpar = (k == 10);  // must be ignored while busy
      @(posedge clk); #1;
      k++;
    end
    s_we = 1'b0; s_limpar = 1'b0;
    check("clr_cycles_a",  32'(k),    32'd32);
    check("clr_ocupado_b", 32'(b_oc), 32'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      s_rs = 5'(i); s_rt = 5'(i);
      #1;
      check("clr_after_rs_a", a_rs, 32'd0);
      check("clr_after_rt_b", b_rt, 32'd0);
    end

    // ---------------- reset mid-clear ----------------
    @(negedge clk);
    s_we = 1'b1; s_rd = 5'd3; s_dados = 32'h0000_0033;
    @(negedge clk);
    s_rd = 5'd20; s_dados = 32'h0000_2020;
    @(negedge clk);
    s_we = 1'b0; s_rs = 5'd20;
    #1;
    check("pre_abort_rs_a", a_rs, 32'h0000_2020);
    @(negedge clk);
    s_limpar = 1'b1;
    @(posedge clk); #1;
    s_limpar = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ocupado_a", 32'(a_oc), 32'd0);
    check("abort_ocupado_b", 32'(b_oc), 32'd0);
    check("abort_r20_a",     a_rs,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_we = 1'b1; s_rd = 5'd4; s_dados = 32'h0000_4444; s_rs = 5'd4;
    @(posedge clk); #1;
    check("first_write_b", b_rs, 32'h0000_4444);
    @(negedge clk);
    s_we = 1'b0;
    #1;
    check("first_write_a", a_rs, 32'h0000_4444);
    s_rs = 5'd20; s_rt = 5'd3;
    #1;
    check("abort_r20_after", a_rs, 32'd0);
    check("abort_r3_after",  a_rt, 32'd0);

    // ---------------- 20 x 16 bank ----------------
    @(negedge clk);
    c_we = 1'b1; c_rd = 5'd25; c_rs = 5'd25; c_dados = 16'hBEEF;
    #1;
    check("c_oob_bypass", 32'(c_lrs), 32'd0);
    @(negedge clk);
    c_rd = 5'd19; c_dados = 16'h1919;
    @(negedge clk);
    c_we = 1'b0; c_rs = 5'd30; c_rt = 5'd19;
    #1;
    check("c_read30",  32'(c_lrs), 32'd0);
    check("c_read19",  32'(c_lrt), 32'h0000_1919);
    c_rs = 5'd25;
    #1;
    check("c_read25",  32'(c_lrs), 32'd0);
    c_rs = 5'd5;
    #1;
    check("c_no_alias5", 32'(c_lrs), 32'd0);
    @(negedge clk);
    c_limpar = 1'b1;
    @(posedge clk); #1;
    c_limpar = 1'b0;
    check("c_ocupado", 32'(c_oc), 32'd1);
    k = 0;
    while (c_oc && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("c_clr_cycles", 32'(k), 32'd20);
    @(negedge clk);
    #1;
    check("c_after_clr19", 32'(c_lrt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_banco_registradores_parametrizado
`default_nettype wire
